// File: rtl/bp_pkg.sv
// Shared definitions for the gshare/gselect branch predictor.
//   - index_mode encodings (BP_GSHARE, BP_GSELECT)
//   - predictor FSM state type (ST_INIT, ST_RUN)
//   - bp_sat_next(): saturating counter step for counters up to 4 bits wide
package bp_pkg;

  localparam int BP_GSHARE  = 0;
  localparam int BP_GSELECT = 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } bp_state_e;

  // Step an n-bit saturating counter (n <= 4) held in the low bits of count.
  function automatic logic [3:0] bp_sat_next(input logic [3:0] count,
                                             input logic taken,
                                             input int unsigned n);
    logic [3:0] lim;
    lim = 4'((5'd1 << n) - 5'd1);
    if (taken) begin
      return (count >= lim) ? lim : count + 4'd1;
    end
    return (count == 4'd0) ? 4'd0 : count - 4'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter_update.sv
// Combinational saturating-counter next-state logic.
// Ports:
//   count_i  [n-1:0]  current counter value
//   taken_i           resolved branch direction
//   count_o  [n-1:0]  counter after the update (clamped at 0 and 2^n-1)
module bp_sat_counter_update
  import bp_pkg::*;
#(
  parameter int n = 2
) (
  input  logic [n-1:0] count_i,
  input  logic         taken_i,
  output logic [n-1:0] count_o
);

  assign count_o = n'(bp_sat_next(4'(count_i), taken_i, n));

endmodule

// File: rtl/gshare_branch_predictor.sv
// Global-history branch predictor with a single PHT of n-bit saturating
// counters, indexed by gshare (address XOR GHR) or gselect ({address, GHR}).
// After reset an INIT sweep writes weakly-not-taken into every entry; ready
// rises once the sweep is done. Lookups shift their prediction into the GHR
// speculatively; a mispredict update restores it from the returned history.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ready                        init sweep complete
//   lookup_valid/lookup_address  prediction request
//   pred_valid, prediction       result, one cycle after an accepted lookup
//   pred_index, pred_history     index and pre-shift GHR, returned with update
//   update_valid/_index/_history/_taken/_mispredict  resolution feedback
//
// Build option: define GSHARE_BYPASS_EN to forward a same-cycle update to a
// lookup of the same index (default: lookup sees the pre-update counter).
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int address_width = 8,
  parameter int m             = 4,
  parameter int n             = 2,
  parameter int index_mode    = BP_GSHARE,
  localparam int IW = (index_mode == BP_GSELECT) ? address_width + m : address_width
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     lookup_valid,
  input  logic [address_width-1:0] lookup_address,
  output logic                     pred_valid,
  output logic                     prediction,
  output logic [IW-1:0]            pred_index,
  output logic [m-1:0]             pred_history,
  input  logic                     update_valid,
  input  logic [IW-1:0]            update_index,
  input  logic [m-1:0]             update_history,
  input  logic                     update_taken,
  input  logic                     update_mispredict
);

  localparam int DEPTH = 1 << IW;
  localparam logic [n-1:0] WNT = n'((1 << (n - 1)) - 1);

  logic [n-1:0]  pht_q [DEPTH];
  bp_state_e     state_q, state_d;
  logic [IW-1:0] ptr_q;
  logic [m-1:0]  ghr_q, ghr_d, ghr_spec, ghr_recover;
  logic          pred_valid_q, prediction_q;
  logic [IW-1:0] pred_index_q;
  logic [m-1:0]  pred_history_q;

  logic [IW-1:0] lookup_idx;
  logic          lookup_fire, update_fire, pred_bit;
  logic [n-1:0]  upd_next;

  assign lookup_fire = lookup_valid && (state_q == ST_RUN);
  assign update_fire = update_valid && (state_q == ST_RUN);

  generate
    if (index_mode == BP_GSELECT) begin : g_gselect
      assign lookup_idx = {lookup_address, ghr_q};
    end else begin : g_gshare
      assign lookup_idx = lookup_address ^ IW'(ghr_q);
    end
  endgenerate

  bp_sat_counter_update #(.n(n)) u_sat (
    .count_i (pht_q[update_index]),
    .taken_i (update_taken),
    .count_o (upd_next)
  );

`ifdef GSHARE_BYPASS_EN
  assign pred_bit = (update_fire && (update_index == lookup_idx))
                    ? upd_next[n-1] : pht_q[lookup_idx][n-1];
`else
  assign pred_bit = pht_q[lookup_idx][n-1];
`endif

  // History shift/recovery; m == 1 has no older bits to keep.
  generate
    if (m == 1) begin : g_hist1
      logic unused_hist;
      assign unused_hist = ^{update_history, ghr_q};
      assign ghr_spec    = pred_bit;
      assign ghr_recover = update_taken;
    end else begin : g_histn
      logic unused_hist_msb;
      assign unused_hist_msb = update_history[m-1];
      assign ghr_spec    = {ghr_q[m-2:0], pred_bit};
      assign ghr_recover = {update_history[m-2:0], update_taken};
    end
  endgenerate

  // Recovery takes priority: the concurrent lookup is younger and is flushed.
  always_comb begin
    ghr_d = ghr_q;
    if (update_fire && update_mispredict) begin
      ghr_d = ghr_recover;
    end else if (lookup_fire) begin
      ghr_d = ghr_spec;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (ptr_q == {IW{1'b1}}) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_INIT;
      ptr_q          <= '0;
      ghr_q          <= '0;
      pred_valid_q   <= 1'b0;
      prediction_q   <= 1'b0;
      pred_index_q   <= '0;
      pred_history_q <= '0;
    end else begin
      state_q      <= state_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= lookup_fire;
      if (state_q == ST_INIT) begin
        ptr_q <= ptr_q + 1'b1;
      end
      if (lookup_fire) begin
        prediction_q   <= pred_bit;
        pred_index_q   <= lookup_idx;
        pred_history_q <= ghr_q;
      end
    end
  end

  // PHT storage carries no reset; the INIT sweep initialises it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        pht_q[ptr_q] <= WNT;
      end else if (update_fire) begin
        pht_q[update_index] <= upd_next;
      end
    end
  end

  assign ready        = (state_q == ST_RUN);
  assign pred_valid   = pred_valid_q;
  assign prediction   = prediction_q;
  assign pred_index   = pred_index_q;
  assign pred_history = pred_history_q;

endmodule
